// File: rtl/filt_mem_stream.sv
// filt_mem_stream
//   Holds one packed filter frame and replays its weights to a processing
//   element one at a time, reuse_cnt passes per frame, highest-index weight
//   first. After the last pass the untouched frame is forwarded downstream.
//
//   Build option: define FILT_MEM_DOUBLE_BUF_EN to add a shadow buffer.
//   The next frame can then be accepted while the current one is streaming,
//   and it is promoted straight into the active buffer on the forwarding
//   handshake.
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     frame_in_valid/ready/data       packed frame input (weight k at [DWIDTH*k +: DWIDTH])
//     reuse_cnt                       passes for the offered frame (saturated to MAX_REUSE)
//     single_valid/ready/data/last    one-weight-per-handshake stream to the PE
//     frame_out_valid/ready/data      copy of the frame after all passes
//     busy                            high whenever the FSM is not idle
//
//   state  | meaning
//   IDLE   | no frame held; ready for a new one
//   STREAM | replaying weights of the active frame
//   FWD    | offering the active frame downstream

module filt_mem_stream #(
    parameter int DWIDTH    = 8,
    parameter int FILT_LEN  = 3,
    parameter int MAX_REUSE = 15,
    localparam int RW       = $clog2(MAX_REUSE + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_in_valid,
    output logic                       frame_in_ready,
    input  logic [DWIDTH*FILT_LEN-1:0] frame_in_data,
    input  logic [RW-1:0]              reuse_cnt,
    output logic                       single_valid,
    input  logic                       single_ready,
    output logic [DWIDTH-1:0]          single_data,
    output logic                       single_last,
    output logic                       frame_out_valid,
    input  logic                       frame_out_ready,
    output logic [DWIDTH*FILT_LEN-1:0] frame_out_data,
    output logic                       busy
);

    localparam int FW = DWIDTH * FILT_LEN;
    localparam int PW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [PW-1:0] PTR_TOP = PW'(FILT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FWD    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] act_data_q, act_data_d;
    logic [RW-1:0] act_reuse_q, act_reuse_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [RW-1:0] pass_q, pass_d;

`ifdef FILT_MEM_DOUBLE_BUF_EN
    logic [FW-1:0] shd_data_q, shd_data_d;
    logic [RW-1:0] shd_reuse_q, shd_reuse_d;
    logic          shd_full_q, shd_full_d;
`endif

    logic          in_acc;
    logic          sgl_hs;
    logic          out_hs;
    logic          last_pass;
    logic [RW-1:0] in_reuse_sat;
    logic          load_en;
    logic [FW-1:0] load_data;
    logic [RW-1:0] load_reuse;

    assign in_acc = frame_in_valid && frame_in_ready;
    assign sgl_hs = single_valid && single_ready;
    assign out_hs = frame_out_valid && frame_out_ready;

    // pass_q counts completed passes, so the current pass is the final one
    // when one more would reach the latched reuse count.
    assign last_pass = ((pass_q + RW'(1)) == act_reuse_q);

    // Compared as int so a MAX_REUSE equal to the port's full range does not
    // produce a degenerate compare.
    assign in_reuse_sat = (int'(reuse_cnt) > MAX_REUSE) ? RW'(MAX_REUSE) : reuse_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            act_data_q  <= '0;
            act_reuse_q <= '0;
            ptr_q       <= '0;
            pass_q      <= '0;
`ifdef FILT_MEM_DOUBLE_BUF_EN
            shd_data_q  <= '0;
            shd_reuse_q <= '0;
            shd_full_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            act_data_q  <= act_data_d;
            act_reuse_q <= act_reuse_d;
            ptr_q       <= ptr_d;
            pass_q      <= pass_d;
`ifdef FILT_MEM_DOUBLE_BUF_EN
            shd_data_q  <= shd_data_d;
            shd_reuse_q <= shd_reuse_d;
            shd_full_q  <= shd_full_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        act_data_d  = act_data_q;
        act_reuse_d = act_reuse_q;
        ptr_d       = ptr_q;
        pass_d      = pass_q;
        load_en     = 1'b0;
        load_data   = frame_in_data;
        load_reuse  = in_reuse_sat;
`ifdef FILT_MEM_DOUBLE_BUF_EN
        shd_data_d  = shd_data_q;
        shd_reuse_d = shd_reuse_q;
        shd_full_d  = shd_full_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_acc) begin
                    load_en = 1'b1;
                end
            end
            S_STREAM: begin
                if (sgl_hs) begin
                    if (ptr_q == '0) begin
                        if (last_pass) begin
                            state_d = S_FWD;
                        end else begin
                            pass_d = pass_q + RW'(1);
                            ptr_d  = PTR_TOP;
                        end
                    end else begin
                        ptr_d = ptr_q - PW'(1);
                    end
                end
            end
            S_FWD: begin
                if (out_hs) begin
`ifdef FILT_MEM_DOUBLE_BUF_EN
                    if (shd_full_q) begin
                        load_en    = 1'b1;
                        load_data  = shd_data_q;
                        load_reuse = shd_reuse_q;
                        shd_full_d = 1'b0;
                    end else if (in_acc) begin
                        // Shadow was empty this cycle, so the new frame
                        // bypasses it and goes straight to the active buffer.
                        load_en = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef FILT_MEM_DOUBLE_BUF_EN
        if (in_acc && (state_q != S_IDLE) && !((state_q == S_FWD) && out_hs)) begin
            shd_data_d  = frame_in_data;
            shd_reuse_d = in_reuse_sat;
            shd_full_d  = 1'b1;
        end
`endif

        if (load_en) begin
            act_data_d  = load_data;
            act_reuse_d = load_reuse;
            ptr_d       = PTR_TOP;
            pass_d      = '0;
            state_d     = (load_reuse == '0) ? S_FWD : S_STREAM;
        end
    end

    always_comb begin
        // Gated by rst_n so the input side reports not-ready while reset is held.
`ifdef FILT_MEM_DOUBLE_BUF_EN
        frame_in_ready  = rst_n && ((state_q == S_IDLE) || !shd_full_q);
`else
        frame_in_ready  = rst_n && (state_q == S_IDLE);
`endif
        single_valid    = (state_q == S_STREAM);
        single_data     = act_data_q[int'(ptr_q)*DWIDTH +: DWIDTH];
        single_last     = (state_q == S_STREAM) && (ptr_q == '0) && last_pass;
        frame_out_valid = (state_q == S_FWD);
        frame_out_data  = act_data_q;
        busy            = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_filt_mem_stream.sv
// Directed testbench for filt_mem_stream (DWIDTH=8, FILT_LEN=3, MAX_REUSE=15).
module tb_filt_mem_stream;

    localparam int DW = 8;
    localparam int FL = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_in_valid;
    logic          frame_in_ready;
    logic [23:0]   frame_in_data;
    logic [3:0]    reuse_cnt;
    logic          single_valid;
    logic          single_ready;
    logic [7:0]    single_data;
    logic          single_last;
    logic          frame_out_valid;
    logic          frame_out_ready;
    logic [23:0]   frame_out_data;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    filt_mem_stream #(.DWIDTH(DW), .FILT_LEN(FL), .MAX_REUSE(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_in_valid (frame_in_valid),
        .frame_in_ready (frame_in_ready),
        .frame_in_data  (frame_in_data),
        .reuse_cnt      (reuse_cnt),
        .single_valid   (single_valid),
        .single_ready   (single_ready),
        .single_data    (single_data),
        .single_last    (single_last),
        .frame_out_valid(frame_out_valid),
        .frame_out_ready(frame_out_ready),
        .frame_out_data (frame_out_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] frame;
        logic [3:0]  reuse;
        int          n_exp;     // expected single handshakes
        bit          toggle;    // single_ready alternates 1/0
        int          fo_delay;  // cycles frame_out_ready is held low
        bit          junk;      // offer a stray frame while streaming
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int idx = 0;
        int fo_seen = 0;
        int last_hs_c = 0;
        int exp_k;
        bit stalled = 1'b0;
        bit done = 1'b0;
        logic [7:0] held = '0;
        frame_in_data   = v.frame;
        reuse_cnt       = v.reuse;
        frame_in_valid  = 1'b1;
        single_ready    = 1'b0;
        frame_out_ready = 1'b0;
        chk({tag, "_in_rdy"}, 64'(frame_in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        frame_in_valid = 1'b0;
        frame_in_data  = 24'h5A5A5A;
        chk({tag, "_sv_first"}, 64'(single_valid), 64'(v.n_exp > 0));
        for (int c = 1; c <= 400 && !done; c++) begin
            single_ready    = v.toggle ? c[0] : 1'b1;
            frame_out_ready = frame_out_valid && (fo_seen >= v.fo_delay);
`ifndef FILT_MEM_DOUBLE_BUF_EN
            frame_in_valid  = v.junk && single_valid;
            if (frame_in_valid) chk({tag, "_junk_rdy"}, 64'(frame_in_ready), 64'd0);
`endif
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (stalled) chk({tag, "_hold"}, 64'(single_data), 64'(held));
            stalled = 1'b0;
            if (single_valid) begin
                if (single_ready) begin
                    exp_k = FL - 1 - (idx % FL);
                    chk({tag, "_data"}, 64'(single_data), 64'(v.frame[8*exp_k +: 8]));
                    chk({tag, "_last"}, 64'(single_last), 64'(idx == v.n_exp - 1));
                    idx++;
                    last_hs_c = c;
                end else begin
                    stalled = 1'b1;
                    held    = single_data;
                end
            end
            if (frame_out_valid) begin
                if (fo_seen == 0) begin
                    chk({tag, "_n_singles"}, 64'(idx), 64'(v.n_exp));
                    if (v.n_exp == 0) chk({tag, "_fo_lat"}, 64'(c), 64'd1);
                end
                chk({tag, "_fo_data"}, 64'(frame_out_data), 64'(v.frame));
                if (frame_out_ready) done = 1'b1;
                fo_seen++;
            end
            @(posedge clk); @(negedge clk);
        end
        frame_in_valid  = 1'b0;
        frame_out_ready = 1'b0;
        single_ready    = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        if (!v.toggle && v.n_exp > 0) chk({tag, "_back2back"}, 64'(last_hs_c), 64'(v.n_exp));
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_rdy"}, 64'(frame_in_ready), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_rdy"}, 64'(frame_in_ready), 64'd0);
        chk({tag, "_sv"},     64'(single_valid), 64'd0);
        chk({tag, "_sl"},     64'(single_last), 64'd0);
        chk({tag, "_fov"},    64'(frame_out_valid), 64'd0);
        chk({tag, "_busy"},   64'(busy), 64'd0);
        chk({tag, "_sd"},     64'(single_data), 64'd0);
        chk({tag, "_fod"},    64'(frame_out_data), 64'd0);
    endtask

    initial begin
        int n;
        rst_n           = 1'b0;
        frame_in_valid  = 1'b0;
        frame_in_data   = '0;
        reuse_cnt       = '0;
        single_ready    = 1'b0;
        frame_out_ready = 1'b0;

        vecs[0] = '{24'h030201, 4'd3,  9, 1'b0, 0, 1'b0};
        vecs[1] = '{24'hAABBCC, 4'd0,  0, 1'b0, 0, 1'b0};
        vecs[2] = '{24'h112233, 4'd3,  9, 1'b1, 2, 1'b0};
        vecs[3] = '{24'h0F0E0D, 4'd1,  3, 1'b0, 1, 1'b1};
        // 255 on a 4-bit port arrives as 15, the saturation ceiling
        vecs[4] = '{24'hDEADBE, 4'hF, 45, 1'b0, 0, 1'b0};
        vecs[5] = '{24'h445566, 4'd2,  6, 1'b1, 0, 1'b1};

        @(negedge clk); @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset one cycle after the 4th weight, then a new frame must start clean.
        frame_in_data  = 24'h030201;
        reuse_cnt      = 4'd3;
        frame_in_valid = 1'b1;
        single_ready   = 1'b1;
        @(posedge clk); @(negedge clk);
        frame_in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (single_valid && single_ready) n++;
            @(posedge clk); @(negedge clk);
        end
        chk("mid_rst_hs4", 64'(n), 64'd4);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", 64'(frame_in_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        run_vec('{24'h0A0B0C, 4'd2, 6, 1'b0, 0, 1'b0}, "after_rst");

`ifdef FILT_MEM_DOUBLE_BUF_EN
        begin
            logic [7:0]  exp_sd [1:9];
            logic [23:0] exp_fo [1:9];
            bit          exp_sv [1:9];
            bit          exp_fv [1:9];
            exp_sv = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
            exp_fv = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
            exp_sd = '{8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
            exp_fo = '{24'h0, 24'h0, 24'h0, 24'h0A0B0C, 24'h0, 24'h0, 24'h0, 24'h010203, 24'h0};
            single_ready    = 1'b1;
            frame_out_ready = 1'b1;
            frame_in_data   = 24'h0A0B0C;
            reuse_cnt       = 4'd1;
            frame_in_valid  = 1'b1;
            @(posedge clk); @(negedge clk);
            frame_in_data  = 24'h010203;
            chk("db_b_rdy", 64'(frame_in_ready), 64'd1);
            for (int c = 1; c <= 9; c++) begin
                if (c == 2) begin
                    frame_in_valid = 1'b0;
                    chk("db_shadow_full_rdy", 64'(frame_in_ready), 64'd0);
                end
                chk($sformatf("db_sv_c%0d", c), 64'(single_valid), 64'(exp_sv[c]));
                chk($sformatf("db_fv_c%0d", c), 64'(frame_out_valid), 64'(exp_fv[c]));
                chk($sformatf("db_busy_c%0d", c), 64'(busy), 64'(c != 9));
                if (exp_sv[c]) chk($sformatf("db_sd_c%0d", c), 64'(single_data), 64'(exp_sd[c]));
                if (exp_fv[c]) chk($sformatf("db_fo_c%0d", c), 64'(frame_out_data), 64'(exp_fo[c]));
                @(posedge clk); @(negedge clk);
            end
            single_ready    = 1'b0;
            frame_out_ready = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/filt_mem_stream.md
FILT_MEM_STREAM -- requirements
Module: filt_mem_stream

Interface
REQ-001 Parameter DWIDTH, default 8: bits per filter weight.
REQ-002 Parameter FILT_LEN, default 3, legal 1..16: weights per filter frame.
REQ-003 Parameter MAX_REUSE, default 15, legal 1..255: largest legal reuse count; RW = $clog2(MAX_REUSE+1).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 frame_in_valid  in  1  upstream frame offered.
REQ-007 frame_in_ready  out  1  block accepts frame this cycle.
REQ-008 frame_in_data  in  DWIDTH*FILT_LEN  packed frame; weight k at bits [DWIDTH*(k+1)-1 : DWIDTH*k].
REQ-009 reuse_cnt  in  RW  passes per frame, sampled with the frame.
REQ-010 single_valid  out  1  one weight offered to the PE.
REQ-011 single_ready  in  1  PE accepts the weight.
REQ-012 single_data  out  DWIDTH  current weight.
REQ-013 single_last  out  1  high with the final weight of the final pass.
REQ-014 frame_out_valid  out  1  frame offered downstream.
REQ-015 frame_out_ready  in  1  downstream accepts frame.
REQ-016 frame_out_data  out  DWIDTH*FILT_LEN  unmodified copy of the accepted frame.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 A handshake on any port SHALL complete on a rising edge where both valid and ready are high.
REQ-019 FSM states SHALL be IDLE, STREAM and FWD; all outputs SHALL be registered or decoded from registered state only.
REQ-020 In IDLE, frame_in_ready SHALL be 1; on accept, the frame and reuse_cnt (saturated to MAX_REUSE) SHALL be latched into the active buffer.
REQ-021 An accept with latched reuse >= 1 SHALL enter STREAM; single_valid SHALL rise in the cycle after the accept edge.
REQ-022 An accept with reuse = 0 SHALL enter FWD directly and emit no weights.
REQ-023 Each pass in STREAM SHALL send weights in the order k = FILT_LEN-1 down to 0; the pointer SHALL advance only on a single handshake.
REQ-024 After weight 0, the pass counter SHALL increment; the pointer SHALL wrap to FILT_LEN-1 with no bubble cycle.
REQ-025 The single handshake for weight 0 on pass reuse SHALL have single_last=1 and SHALL move the FSM to FWD.
REQ-026 single_valid, single_data and single_last SHALL hold stable while single_ready=0.
REQ-027 In FWD, frame_out_valid SHALL be 1 with frame_out_data stable until the handshake, then IDLE.
REQ-028 Totals per frame: exactly reuse*FILT_LEN single handshakes, then exactly one frame_out handshake.
REQ-029 frame_in_valid=1 outside IDLE SHALL be ignored (not latched) unless REQ-034 applies.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and clear the pointer, pass counter and buffer-full flags.
REQ-031 Output values during reset: frame_in_ready=0, single_valid=0, single_last=0, frame_out_valid=0, busy=0, single_data=0, frame_out_data=0.
REQ-032 Reset mid-frame SHALL drop the frame; frame_in_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-033 Macro FILT_MEM_DOUBLE_BUF_EN SHALL select double buffering; without it, one buffer and REQ-020/REQ-029 apply.
REQ-034 With the macro, a shadow buffer SHALL exist; frame_in_ready SHALL equal (state==IDLE) || !shadow_full; an accept outside IDLE SHALL fill the shadow.
REQ-035 With the macro, on the FWD handshake with shadow_full=1, the shadow SHALL move to the active buffer on the same edge and the FSM SHALL enter STREAM (or FWD if reuse=0), skipping IDLE.
REQ-036 With the macro, an accept in the same cycle as the transfer SHALL be allowed only if shadow was empty at the start of that cycle.

Verification
REQ-037 FILT_LEN=3, frame 0x030201, reuse=3, ready always 1 -> singles 03,02,01 x3 on 9 consecutive cycles, single_last on the 9th, then frame_out 0x030201.
REQ-038 reuse=0 -> no single_valid; frame_out_valid 1 cycle after the accept.
REQ-039 single_ready toggling 1/0 each cycle -> data holds while stalled; 9 handshakes total; order unchanged.
REQ-040 rst_n low for 1 cycle after the 4th weight -> all valids 0; the next frame streams from weight 2, pass 1.
REQ-041 reuse_cnt=255 with MAX_REUSE=15 -> exactly 15*FILT_LEN weights.
REQ-042 With FILT_MEM_DOUBLE_BUF_EN: frame B offered during A's STREAM -> B accepted; B's first weight one cycle after A's frame_out handshake; busy never drops.
